// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream, packs it little-endian into 32-bit
// words and writes them to instruction memory. The core is held in reset
// until a load completes successfully.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to accept one trailing
// checksum byte. The load succeeds only if the 8-bit sum of every payload
// byte plus the checksum byte is zero.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_q;
    logic              xfer;
    logic [ADDR_W:0]   word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic [7:0]        sum_nxt;
`endif

    // in_ready is registered, so a transfer is a plain AND of the handshake
    assign xfer     = in_valid & in_ready;
    assign word_nxt = word_cnt + ONE_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign sum_nxt  = sum_q + in_data;
`endif

    // Load sequencer: state, counters, word assembly and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len_q        <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // write strobe is a single-cycle pulse, raised only on the 4th byte
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q        <= len;
                        word_cnt     <= '0;
                        byte_cnt     <= '0;
                        asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_reset_n <= 1'b0;
                        if (len > DEPTH_W) begin
                            // oversize program: refuse without touching memory
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            state    <= IDLE;
                        end else if (len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= CHECK;
`else
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                            busy         <= 1'b0;
                            in_ready     <= 1'b0;
                            state        <= DONE;
`endif
                        end else begin
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        // shift in from the top: after 4 bytes byte 0 sits in 7:0
                        asm_q    <= {in_data, asm_q[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q    <= sum_nxt;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {in_data, asm_q[31:8]};
                            in_ready   <= 1'b0;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_nxt;
                    if (word_nxt == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        in_ready <= 1'b1;
                        state    <= CHECK;
`else
                        done         <= 1'b1;
                        core_reset_n <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
`endif
                    end else begin
                        in_ready <= 1'b1;
                        state    <= RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (sum_nxt == 8'd0) begin
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                            state        <= DONE;
                        end else begin
                            error <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a scoreboard of expected memory writes is filled
// as each load is driven, and a monitor pops and compares on every imem_we.
// Follows IMEM_LOADER_CHECKSUM_EN when it is defined.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset_n;
    logic              busy;
    logic              done;
    logic              error;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_err = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // every write strobe must match the oldest expected write
    always @(negedge clk) begin : mon
        wr_t e;
        if (imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {24'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                chk("wr_data", imem_wdata, e.data);
                chk("rdy_in_write", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"},       {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"},     {24'd0, imem_addr}, 32'd0);
        chk({tag, "_wdata"},    imem_wdata, 32'd0);
        chk({tag, "_core_rn"},  {31'd0, core_reset_n}, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, done}, 32'd0);
        chk({tag, "_error"},    {31'd0, error}, 32'd0);
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[ADDR_W:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // offer bytes in order; a byte advances only on a sampled valid&&ready
    task automatic stream(input logic [7:0] b[$], input bit toggle);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit xf;
        while (i < b.size() && cyc < 20 * b.size() + 20) begin
            in_valid = toggle ? ph : 1'b1;
            in_data  = b[i];
            xf = in_valid && in_ready;
            @(posedge clk); #1;
            if (xf) i++;
            ph = ~ph;
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        chk("stream_bytes", i, b.size());
    endtask

    task automatic to_bytes(input logic [31:0] w[$], output logic [7:0] b[$], output logic [7:0] s);
        b = {};
        s = 8'd0;
        for (int i = 0; i < w.size(); i++)
            for (int k = 0; k < 4; k++) begin
                b.push_back(w[i][8*k +: 8]);
                s = s + w[i][8*k +: 8];
            end
    endtask

    task automatic push_exp(input logic [31:0] w[$]);
        wr_t e;
        for (int i = 0; i < w.size(); i++) begin
            e.addr = i[ADDR_W-1:0];
            e.data = w[i];
            exp_q.push_back(e);
        end
    endtask

    // called right after the last payload byte has been accepted
    task automatic finish_load(input logic [7:0] s, input bit bad, input bit had_write);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] cq[$];
        logic [7:0] c;
        c = 8'(8'd0 - s);
        if (bad) c = c + 8'd1;
        if (had_write) chk("we_last", {31'd0, imem_we}, 32'd1);
        cq = {};
        cq.push_back(c);
        stream(cq, 1'b0);
        if (bad) begin
            chk("cks_error",   {31'd0, error}, 32'd1);
            chk("cks_core_rn", {31'd0, core_reset_n}, 32'd0);
            chk("cks_done",    {31'd0, done}, 32'd0);
            chk("cks_busy",    {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            chk("cks_idle_rdy", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("done",    {31'd0, done}, 32'd1);
            chk("core_rn", {31'd0, core_reset_n}, 32'd1);
            chk("busy",    {31'd0, busy}, 32'd0);
            chk("error",   {31'd0, error}, 32'd0);
        end
`else
        if (bad) $display("note: checksum disabled, bad flag ignored (sum 0x%0h)", s);
        if (had_write) begin
            chk("we_last",   {31'd0, imem_we}, 32'd1);
            chk("busy_wr",   {31'd0, busy}, 32'd1);
            chk("done_early",{31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        chk("done",    {31'd0, done}, 32'd1);
        chk("core_rn", {31'd0, core_reset_n}, 32'd1);
        chk("busy",    {31'd0, busy}, 32'd0);
        chk("error",   {31'd0, error}, 32'd0);
`endif
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    task automatic load(input logic [31:0] w[$], input bit toggle, input bit bad);
        logic [7:0] b[$];
        logic [7:0] s;
        to_bytes(w, b, s);
        push_exp(w);
        do_start(w.size());
        if (w.size() > 0) stream(b, toggle);
        finish_load(s, bad, w.size() > 0);
    endtask

    initial begin : main
        logic [31:0] w2[$];
        logic [31:0] w3[$];
        logic [31:0] wf[$];
        logic [31:0] wnone[$];
        logic [7:0]  b[$];
        logic [7:0]  bpart[$];
        logic [7:0]  s;

        reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 8'd0;
        #3;
        check_reset_vals("por");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_core_rn", {31'd0, core_reset_n}, 32'd0);
        chk("post_rst_busy",    {31'd0, busy}, 32'd0);

        // basic two-word program, valid held high
        w2 = {32'h0050_0013, 32'h0010_0093};
        load(w2, 1'b0, 1'b0);

        // same program with valid toggling every cycle, restarted from DONE
        load(w2, 1'b1, 1'b0);

        // empty program
        wnone = {};
        load(wnone, 1'b0, 1'b0);

        // oversize program is refused
        do_start(DEPTH + 1);
        chk("big_error",   {31'd0, error}, 32'd1);
        chk("big_core_rn", {31'd0, core_reset_n}, 32'd0);
        chk("big_done",    {31'd0, done}, 32'd0);
        chk("big_busy",    {31'd0, busy}, 32'd0);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("big_rdy",    {31'd0, in_ready}, 32'd0);
        chk("big_sticky", {31'd0, error}, 32'd1);

        // start ignored while receiving: len and counters must survive
        w3 = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
        to_bytes(w3, b, s);
        push_exp(w3);
        do_start(3);
        bpart = b[0:1];
        stream(bpart, 1'b0);
        start = 1'b1; len = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_rdy",  {31'd0, in_ready}, 32'd1);
        bpart = b[2:11];
        stream(bpart, 1'b0);
        finish_load(s, 1'b0, 1'b1);

        // full-depth program: last address is DEPTH-1
        wf = {};
        for (int i = 0; i < DEPTH; i++) wf.push_back((i * 32'h0101_0101) ^ 32'hA500_005A);
        load(wf, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // bad checksum leaves the core held
        load(w2, 1'b0, 1'b1);
`endif

        // reset in the middle of a load, after 6 of 8 bytes
        to_bytes(w2, b, s);
        w3 = {32'h0050_0013};
        push_exp(w3);
        do_start(2);
        bpart = b[0:5];
        stream(bpart, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        in_valid = 1'b1; in_data = 8'h10;
        repeat (4) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_core_rn", {31'd0, core_reset_n}, 32'd0);
        chk("rel_done",    {31'd0, done}, 32'd0);
        chk("rel_busy",    {31'd0, busy}, 32'd0);
        chk("midrst_sb",   exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
